// File: rtl/dvi_video_controller.sv
// DVI video controller: raster timing generation, 15-bit RGB pixel intake and
// packing into two 12-bit half-words for an external DDR output register.
module dvi_video_controller #(
  parameter int HORI_FRONT_PORCH  = 24,
  parameter int HORI_SYNC_PULSE   = 136,
  parameter int HORI_BACK_PORCH   = 160,
  parameter int HORI_VISIBLE_AREA = 1024,
  parameter int VERT_FRONT_PORCH  = 3,
  parameter int VERT_SYNC_PULSE   = 6,
  parameter int VERT_BACK_PORCH   = 29,
  parameter int VERT_VISIBLE_AREA = 768,
  parameter int SYNC_POLARITY     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  pixel_r,
  input  logic [4:0]  pixel_g,
  input  logic [4:0]  pixel_b,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic [11:0] dvi_data_b,
  output logic [11:0] dvi_data_a,
  output logic        dvi_de,
  output logic        dvi_h,
  output logic        dvi_v,
  output logic        frame_start,
  output logic        underflow
);

  localparam int HW  = HORI_FRONT_PORCH + HORI_SYNC_PULSE + HORI_BACK_PORCH + HORI_VISIBLE_AREA;
  localparam int VW  = VERT_FRONT_PORCH + VERT_SYNC_PULSE + VERT_BACK_PORCH + VERT_VISIBLE_AREA;
  localparam int HCW = (HW > 1) ? $clog2(HW) : 1;
  localparam int VCW = (VW > 1) ? $clog2(VW) : 1;

  // Region boundaries, pre-sized to the counter widths.
  localparam logic [HCW-1:0] H_LAST      = HCW'(HW - 1);
  localparam logic [HCW-1:0] H_SYNC_END  = HCW'(HORI_SYNC_PULSE);
  localparam logic [HCW-1:0] H_ACT_START = HCW'(HORI_SYNC_PULSE + HORI_BACK_PORCH);
  localparam logic [HCW-1:0] H_ACT_END   = HCW'(HORI_SYNC_PULSE + HORI_BACK_PORCH
                                                + HORI_VISIBLE_AREA);
  localparam logic [VCW-1:0] V_LAST       = VCW'(VW - 1);
  localparam logic [VCW-1:0] V_VIS_END    = VCW'(VERT_VISIBLE_AREA);
  localparam logic [VCW-1:0] V_SYNC_START = VCW'(VERT_VISIBLE_AREA + VERT_FRONT_PORCH);
  localparam logic [VCW-1:0] V_SYNC_END   = VCW'(VERT_VISIBLE_AREA + VERT_FRONT_PORCH
                                                 + VERT_SYNC_PULSE);
  localparam logic SYNC_ON = (SYNC_POLARITY != 0);

  logic [HCW-1:0] hc_q, hc_d;
  logic [VCW-1:0] vc_q, vc_d;

  logic        de_q, de_d;
  logic        h_q, h_d;
  logic        v_q, v_d;
  logic        fs_q, fs_d;
  logic        uf_q, uf_d;
  logic [11:0] data_b_q, data_b_d;
  logic [11:0] data_a_q, data_a_d;

  logic v_visible, h_sync_zone, h_active;
  logic hsync_int, vsync_int, de_int;

  // Raster decode: hsync only on visible lines, vsync for whole lines, DE in
  // the active window of visible lines; the three are mutually exclusive.
  assign v_visible   = (vc_q < V_VIS_END);
  assign h_sync_zone = (hc_q < H_SYNC_END);
  assign h_active    = (hc_q >= H_ACT_START) && (hc_q < H_ACT_END);
  assign hsync_int   = v_visible && h_sync_zone;
  assign vsync_int   = (vc_q >= V_SYNC_START) && (vc_q < V_SYNC_END);
  assign de_int      = v_visible && h_active;

  // A pixel is taken whenever DE is active; nothing is taken during reset.
  assign pixel_ready = de_int && !rst;

  // Counter advance: hc wraps each line, vc steps only on the hc wrap.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    hc_d = hc_q + 1'b1;
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
    end
  end

  // Output stage next-state: sync levels, packed pixel data, sticky underflow.
  always_comb begin
    de_d     = de_int;
    h_d      = hsync_int ? SYNC_ON : ~SYNC_ON;
    v_d      = vsync_int ? SYNC_ON : ~SYNC_ON;
    fs_d     = (hc_q == '0) && (vc_q == '0);
    uf_d     = uf_q | (de_int & ~pixel_valid);
    data_b_d = '0;
    data_a_d = '0;
    if (de_int && pixel_valid) begin
      data_b_d = {1'b0, pixel_r, pixel_g[4:3], 4'b0000};
      data_a_d = {pixel_g[2:0], pixel_b, 4'b0000};
    end
  end

  // State and output registers; reset parks the raster on the first front-porch line.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
    if (rst) begin
      hc_q     <= '0;
      vc_q     <= V_VIS_END;
      de_q     <= 1'b0;
      h_q      <= ~SYNC_ON;
      v_q      <= ~SYNC_ON;
      fs_q     <= 1'b0;
      uf_q     <= 1'b0;
      data_b_q <= '0;
      data_a_q <= '0;
    end else begin
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      de_q     <= de_d;
      h_q      <= h_d;
      v_q      <= v_d;
      fs_q     <= fs_d;
      uf_q     <= uf_d;
      data_b_q <= data_b_d;
      data_a_q <= data_a_d;
    end
  end

  assign dvi_de      = de_q;
  assign dvi_h       = h_q;
  assign dvi_v       = v_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;
  assign dvi_data_b  = data_b_q;
  assign dvi_data_a  = data_a_q;

endmodule

// File: tb/tb_dvi_video_controller.sv
// Bench for dvi_video_controller: two instances (active-low and active-high
// sync) share stimulus and are compared every cycle against a raster model
// derived from the absolute cycle count since reset, plus directed vectors.
module tb_dvi_video_controller;

  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 4;
  localparam int HV = 8;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int VV = 4;
  localparam int HW = HF + HS + HB + HV;
  localparam int VW = VF + VS + VB + VV;
  localparam int FW = HW * VW;
  localparam int BASE = VV * HW;  // raster index of the post-reset state

  typedef struct packed {
    logic        ready;
    logic        h;
    logic        v;
    logic        de;
    logic        fs;
    logic        uf;
    logic [11:0] b;
    logic [11:0] a;
  } obs_t;

  typedef struct {
    logic [4:0]  r;
    logic [4:0]  g;
    logic [4:0]  b;
    logic [11:0] exp_b;
    logic [11:0] exp_a;
  } pix_vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] pixel_r = '0;
  logic [4:0] pixel_g = '0;
  logic [4:0] pixel_b = '0;
  logic       pixel_valid = 1'b1;

  logic        ready_0, de_0, h_0, v_0, fs_0, uf_0;
  logic [11:0] db_0, da_0;
  logic        ready_1, de_1, h_1, v_1, fs_1, uf_1;
  logic [11:0] db_1, da_1;

  int       vectors = 0;
  int       miscompares = 0;
  int       k = 0;            // edges since the last reset edge
  logic     uf_model = 1'b0;
  pix_vec_t pack_tbl [8];

  always #5 clk = ~clk;

  dvi_video_controller #(
    .HORI_FRONT_PORCH(HF), .HORI_SYNC_PULSE(HS), .HORI_BACK_PORCH(HB), .HORI_VISIBLE_AREA(HV),
    .VERT_FRONT_PORCH(VF), .VERT_SYNC_PULSE(VS), .VERT_BACK_PORCH(VB), .VERT_VISIBLE_AREA(VV),
    .SYNC_POLARITY(0)
  ) u_dut_0 (
    .clk(clk), .rst(rst), .pixel_r(pixel_r), .pixel_g(pixel_g), .pixel_b(pixel_b),
    .pixel_valid(pixel_valid), .pixel_ready(ready_0), .dvi_data_b(db_0), .dvi_data_a(da_0),
    .dvi_de(de_0), .dvi_h(h_0), .dvi_v(v_0), .frame_start(fs_0), .underflow(uf_0)
  );

  dvi_video_controller #(
    .HORI_FRONT_PORCH(HF), .HORI_SYNC_PULSE(HS), .HORI_BACK_PORCH(HB), .HORI_VISIBLE_AREA(HV),
    .VERT_FRONT_PORCH(VF), .VERT_SYNC_PULSE(VS), .VERT_BACK_PORCH(VB), .VERT_VISIBLE_AREA(VV),
    .SYNC_POLARITY(1)
  ) u_dut_1 (
    .clk(clk), .rst(rst), .pixel_r(pixel_r), .pixel_g(pixel_g), .pixel_b(pixel_b),
    .pixel_valid(pixel_valid), .pixel_ready(ready_1), .dvi_data_b(db_1), .dvi_data_a(da_1),
    .dvi_de(de_1), .dvi_h(h_1), .dvi_v(v_1), .frame_start(fs_1), .underflow(uf_1)
  );

  function automatic logic is_de(input int s);
    int hc = s % HW;
    int vc = s / HW;
    return (vc < VV) && (hc >= HS + HB) && (hc < HS + HB + HV);
  endfunction

  function automatic int cur_hc();
    return ((BASE + k) % FW) % HW;
  endfunction

  function automatic int cur_vc();
    return ((BASE + k) % FW) / HW;
  endfunction

  // Expected outputs after an edge: so = raster index the outputs were
  // registered from, sc = raster index now held (drives pixel_ready).
  function automatic obs_t expect_obs(input logic in_rst, input int so, input int sc,
                                      input logic pv, input logic [4:0] pr, pg, pb,
                                      input logic pol, input logic uf);
    obs_t e;
    int   hc;
    int   vc;
    e   = '0;
    e.h = ~pol;
    e.v = ~pol;
    if (!in_rst) begin
      hc      = so % HW;
      vc      = so / HW;
      e.ready = is_de(sc);
      if (vc < VV && hc < HS) e.h = pol;
      if (vc >= VV + VF && vc < VV + VF + VS) e.v = pol;
      e.de = is_de(so);
      e.fs = (so == 0);
      e.uf = uf;
      if (e.de && pv) begin
        e.b = {1'b0, pr, pg[4:3], 4'h0};
        e.a = {pg[2:0], pb, 4'h0};
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (k=%0d): got 0x%0h, want 0x%0h", name, k, act, exp);
    end
  endtask

  // One clock: remember the inputs seen at the edge, sample #1 after it and
  // compare both instances with the model, plus the one-hot sync/DE rule.
  task automatic step();
    logic       pv;
    logic [4:0] pr, pg, pb;
    int         so, sc, n0, n1;
    obs_t       o0, o1;
    pv = pixel_valid;
    pr = pixel_r;
    pg = pixel_g;
    pb = pixel_b;
    @(posedge clk);
    #1;
    so = 0;
    sc = 0;
    if (rst) begin
      k        = 0;
      uf_model = 1'b0;
    end else begin
      k++;
      so = (BASE + k - 1) % FW;
      sc = (BASE + k) % FW;
      if (is_de(so) && !pv) uf_model = 1'b1;
    end
    o0 = '{ready_0, h_0, v_0, de_0, fs_0, uf_0, db_0, da_0};
    o1 = '{ready_1, h_1, v_1, de_1, fs_1, uf_1, db_1, da_1};
    check("cycle_pol0", o0, expect_obs(rst, so, sc, pv, pr, pg, pb, 1'b0, uf_model));
    check("cycle_pol1", o1, expect_obs(rst, so, sc, pv, pr, pg, pb, 1'b1, uf_model));
    n0 = int'(h_0 == 1'b0) + int'(v_0 == 1'b0) + int'(de_0 == 1'b1);
    n1 = int'(h_1 == 1'b1) + int'(v_1 == 1'b1) + int'(de_1 == 1'b1);
    check("one_hot_pol0", 32'(n0 <= 1), 32'd1);
    check("one_hot_pol1", 32'(n1 <= 1), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   first_low, low_len, hcount, hpulse, decount, fscount, ufdrop;
    logic prev_h;
    bit   found;

    pack_tbl[0] = '{5'h1F, 5'h15, 5'h03, 12'h7E0, 12'hA30};
    pack_tbl[1] = '{5'h00, 5'h00, 5'h00, 12'h000, 12'h000};
    pack_tbl[2] = '{5'h1F, 5'h1F, 5'h1F, 12'h7F0, 12'hFF0};
    pack_tbl[3] = '{5'h01, 5'h01, 5'h10, 12'h040, 12'h300};
    pack_tbl[4] = '{5'h10, 5'h18, 5'h01, 12'h430, 12'h010};
    pack_tbl[5] = '{5'h0A, 5'h07, 5'h15, 12'h280, 12'hF50};
    pack_tbl[6] = '{5'h15, 5'h0A, 5'h1E, 12'h550, 12'h5E0};
    pack_tbl[7] = '{5'h00, 5'h10, 5'h00, 12'h020, 12'h000};

    // Reset held for 5 edges; every one of them shows reset levels.
    rst = 1'b1;
    repeat (5) step();
    rst = 1'b0;

    // k=1 is the first edge with rst low; vsync output appears 17 edges later
    // (one front-porch line) and lasts two lines.
    first_low = -1;
    low_len   = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (v_0 == 1'b0) begin
        if (first_low < 0) first_low = k;
        low_len++;
      end
    end
    check("vsync_first_low_k", 32'(first_low), 32'd18);
    check("vsync_low_len", 32'(low_len), 32'd34);

    // Line timing over one full frame starting at frame_start.
    found = 1'b0;
    for (int i = 0; i < 2 * FW && !found; i++) begin
      step();
      found = fs_0;
    end
    check("frame_start_seen", 32'(found), 32'd1);
    check("frame_start_with_hsync", 32'(h_0), 32'd0);
    hpulse  = (h_0 == 1'b0) ? 1 : 0;
    hcount  = hpulse;
    decount = int'(de_0);
    fscount = int'(fs_0);
    prev_h  = h_0;
    for (int i = 1; i < FW; i++) begin
      step();
      if (h_0 == 1'b0) hcount++;
      if (h_0 == 1'b0 && prev_h == 1'b1) hpulse++;
      decount += int'(de_0);
      fscount += int'(fs_0);
      prev_h = h_0;
    end
    check("hsync_pulses_per_frame", 32'(hpulse), 32'd4);
    check("hsync_low_cycles", 32'(hcount), 32'd12);
    check("de_cycles_per_frame", 32'(decount), 32'd32);
    check("frame_start_pulses", 32'(fscount), 32'd1);

    // Packing table fed into the 8 active slots of one line.
    found = 1'b0;
    for (int i = 0; i < FW && !found; i++) begin
      if (ready_0) found = 1'b1;
      else step();
    end
    check("pack_ready_seen", 32'(found), 32'd1);
    for (int i = 0; i < 8; i++) begin
      pixel_r     = pack_tbl[i].r;
      pixel_g     = pack_tbl[i].g;
      pixel_b     = pack_tbl[i].b;
      pixel_valid = 1'b1;
      step();
      check($sformatf("pack_de[%0d]", i), 32'(de_0), 32'd1);
      check($sformatf("pack_b[%0d]", i), 32'(db_0), 32'(pack_tbl[i].exp_b));
      check($sformatf("pack_a[%0d]", i), 32'(da_0), 32'(pack_tbl[i].exp_a));
    end

    // Underflow: valid dropped for the 3rd active slot of visible line 1.
    check("underflow_idle", 32'(uf_0), 32'd0);
    pixel_r = 5'h11;
    pixel_g = 5'h0E;
    pixel_b = 5'h07;
    found = 1'b0;
    for (int i = 0; i < 2 * FW && !found; i++) begin
      if (cur_vc() == 1 && cur_hc() == 0) found = 1'b1;
      else step();
    end
    check("uf_line_found", 32'(found), 32'd1);
    decount = 0;
    for (int i = 0; i < HW; i++) begin
      pixel_valid = (cur_hc() != HS + HB + 2);
      step();
      decount += int'(de_0);
      if (i == HS + HB + 2) begin
        check("uf_slot_de", 32'(de_0), 32'd1);
        check("uf_slot_b", 32'(db_0), 32'h000);
        check("uf_slot_a", 32'(da_0), 32'h000);
        check("uf_flag_rise", 32'(uf_0), 32'd1);
      end else if (i == HS + HB + 3) begin
        check("uf_next_slot_b", 32'(db_0), 32'h450);
        check("uf_next_slot_a", 32'(da_0), 32'hC70);
      end
    end
    pixel_valid = 1'b1;
    check("uf_line_de_cycles", 32'(decount), 32'd8);
    ufdrop = 0;
    for (int i = 0; i < FW + HW; i++) begin
      step();
      if (uf_0 !== 1'b1) ufdrop++;
    end
    check("uf_sticky_cycles_low", 32'(ufdrop), 32'd0);

    // One-cycle reset during the active region of line 2.
    found = 1'b0;
    for (int i = 0; i < 2 * FW && !found; i++) begin
      if (cur_vc() == 2 && ready_0) found = 1'b1;
      else step();
    end
    check("rst_point_found", 32'(found), 32'd1);
    rst = 1'b1;
    step();
    check("rst_de", 32'(de_0), 32'd0);
    check("rst_ready", 32'(ready_0), 32'd0);
    check("rst_underflow", 32'(uf_0), 32'd0);
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2 * FW && !found; i++) begin
      step();
      found = fs_0;
    end
    // 68 edges (4 lines of 17) after the first edge with rst low (k=1).
    check("rst_frame_start_k", 32'(k), 32'd69);
    repeat (FW) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
